serial_adder_ctrl: RTL and testbench

Sequencing controller that computes a WIDTH-bit sum with a single one-bit full-adder cell, one bit per clock, LSB first. It latches two operands and a carry-in on a start handshake and walks the bits through the cell, holding the carry in a register between cycles. It presents the completed sum and carry-out with a one-cycle done pulse. It is the area-minimal alternative to a WIDTH-wide ripple adder built from the same full-adder cells.

---
 rtl/serial_adder_ctrl.sv | 125 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder sequencer around a single full-adder cell.
// It processes one bit per clock, LSB first, and keeps the carry in a register
// between cycles. The block returns the WIDTH-bit sum and the carry-out with a
// one-cycle done pulse.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // The counter needs at least one bit so that WIDTH=1 still elaborates.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;

  logic               cell_s;
  logic               cell_c;
  logic               accept;
  logic [WIDTH-1:0]   acc_shifted;

  // The one-bit full-adder cell, fed from the operand LSBs and the held carry.
  assign cell_s = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign cell_c = (opa_q[0] & opb_q[0]) | ((opa_q[0] ^ opb_q[0]) & carry_q);

  // A new request is taken only from IDLE or DONE. A start seen during RUN is dropped.
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  // Shift the new sum bit in at the MSB. Written this way, WIDTH=1 needs no special case.
  always_comb begin
    acc_shifted            = acc_q >> 1;
    acc_shifted[WIDTH-1]   = cell_s;
  end

  // Next-state logic: operand load on accept, one bit per RUN cycle, result capture on the last bit.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    bitcnt_d = bitcnt_q;

    if (accept) begin
      opa_d    = a;
      opb_d    = b;
      carry_d  = cin;
      bitcnt_d = '0;
      state_d  = RUN;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          acc_d    = acc_shifted;
          opa_d    = opa_q >> 1;
          opb_d    = opb_q >> 1;
          carry_d  = cell_c;
          bitcnt_d = bitcnt_q + CNT_W'(1);
          if (bitcnt_q == LAST_BIT) begin
            sum_d   = acc_shifted;
            cout_d  = cell_c;
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    if (!rst_n) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and randomized checks of serial_adder_ctrl.
// Each result is compared with a plain-arithmetic model, a + b + cin, and the
// handshake timing is compared with the documented WIDTH+1 edge latency.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks = 0;
  int n_errors = 0;

  // Expected values of sum and cout while they hold the previous result.
  logic [W-1:0] held_sum  = '0;
  logic         held_cout = 1'b0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge. Outputs are sampled 1 ns later, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one addition from IDLE or DONE and follow it to the done cycle.
  // On return the bench is in the done cycle. The caller decides what start
  // does next: drive 0 to return to IDLE, or 1 for a back-to-back accept.
  // disturb: pulse start in RUN cycle 3 and scramble the operands after the accept.
  task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input bit disturb, input string tag);
    logic [W:0] model;
    model = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc};
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    tick();                                  // accepting edge E0
    start = 1'b0;
    if (disturb) begin
      a = ~ta; b = W'($urandom); cin = ~tc;
    end
    for (int i = 0; i < W; i++) begin
      check({tag, " busy"}, {30'd0, busy, done}, {30'd0, 1'b1, 1'b0});
      check({tag, " hold"}, {23'd0, cout, sum}, {23'd0, held_cout, held_sum});
      start = (disturb && i == 2);
      tick();
    end
    start = 1'b0;
    // The edge just passed is E0+W, so done belongs to this cycle.
    check({tag, " done"}, {30'd0, busy, done}, {30'd0, 1'b0, 1'b1});
    check({tag, " result"}, {23'd0, cout, sum}, {23'd0, model});
    held_sum  = model[W-1:0];
    held_cout = model[W];
  endtask

  // One cycle after a done pulse with start low: back in IDLE, result held.
  task automatic idle_after(input string tag);
    start = 1'b0;
    tick();
    check({tag, " idle"}, {30'd0, busy, done}, 32'd0);
    check({tag, " held"}, {23'd0, cout, sum}, {23'd0, held_cout, held_sum});
  endtask

  initial begin
    // Reset held for two edges with start high.
    rst_n = 1'b0; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    tick();
    tick();
    check("reset outs", {22'd0, busy, done, cout, sum}, 32'd0);
    rst_n = 1'b1; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post reset idle", {22'd0, busy, done, cout, sum}, 32'd0);
    end

    // Directed vectors.
    do_add(8'h3C, 8'h0F, 1'b0, 1'b0, "3C+0F");
    idle_after("3C+0F");
    do_add(8'hA5, 8'h5A, 1'b1, 1'b0, "A5+5A+1");
    idle_after("A5+5A+1");
    do_add(8'hFF, 8'h01, 1'b0, 1'b0, "FF+01");
    idle_after("FF+01");

    // A start during RUN is ignored, and operand changes after the accept have no effect.
    do_add(8'h77, 8'h19, 1'b1, 1'b1, "ignore start");
    idle_after("ignore start");

    // Back-to-back: start high through the done cycle.
    do_add(8'h80, 8'h80, 1'b1, 1'b0, "b2b first");
    do_add(8'h01, 8'h01, 1'b0, 1'b0, "b2b second");
    idle_after("b2b second");

    // Reset in RUN cycle 4 abandons the operation.
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid reset", {22'd0, busy, done, cout, sum}, 32'd0);
    held_sum = '0; held_cout = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check("no done after reset", {30'd0, busy, done}, 32'd0);
    end
    do_add(8'h12, 8'h34, 1'b1, 1'b0, "after reset");
    idle_after("after reset");

    // Randomized operations, with random back-to-back runs and disturbances.
    for (int n = 0; n < 40; n++) begin
      do_add(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), "rand");
      if ($urandom_range(0, 1) == 0) idle_after("rand");
    end
    idle_after("final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
